// File: rtl/mem_store_checker.sv
// Self-check monitor on the core's data-memory write port: matches stores against a
// programmable table of expected (address, data) pairs and reports a sticky verdict.
module mem_store_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_EXP   = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              ordered,
    input  logic [ADDR_W-1:0] ign_lo,
    input  logic [ADDR_W-1:0] ign_hi,
    input  logic              start,
    input  logic              clear,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W:0]    hit_count,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_BAD     = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_EMPTY   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   HIT_ONE  = (IDX_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] tab_addr [N_EXP];
    logic [DATA_W-1:0] tab_data [N_EXP];
    logic [N_EXP-1:0]  tab_vld;
    logic [N_EXP-1:0]  hit;
    logic              ord_q;

    logic [N_EXP-1:0]  pend;
    logic [N_EXP-1:0]  eq_vec;
    logic [N_EXP-1:0]  sel;
    logic              claimed;
    logic              match;
    logic              all_done;
    logic              in_win;
    logic              cfg_write;

    always_comb begin
        pend    = tab_vld & ~hit;
        sel     = '0;
        eq_vec  = '0;
        claimed = 1'b0;
        for (int i = 0; i < N_EXP; i++) begin
            eq_vec[i] = pend[i] && (tab_addr[i] == mem_addr) && (tab_data[i] == mem_wdata);
            // Ordered runs may only consume the lowest pending entry; unordered runs the lowest equal one.
            if (!claimed && (ord_q ? pend[i] : eq_vec[i])) begin
                claimed = 1'b1;
                sel[i]  = eq_vec[i];
            end
        end
    end

    assign match     = |sel;
    assign all_done  = ((pend & ~sel) == '0);
    assign in_win    = (mem_addr >= ign_lo) && (mem_addr <= ign_hi);
    assign cfg_write = cfg_we && !clear && !start && (state != S_RUN) && (int'(cfg_idx) < N_EXP);

    assign busy = (state == S_RUN);
    assign done = (state == S_PASS) || (state == S_FAIL);
    assign pass = (state == S_PASS);

    always_ff @(posedge clk) begin
        if (cfg_write) begin
            tab_addr[cfg_idx] <= cfg_addr;
            tab_data[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            tab_vld     <= '0;
            hit         <= '0;
            ord_q       <= 1'b0;
            hit_count   <= '0;
            cycle_count <= '0;
            fail_code   <= FC_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else if (clear) begin
            state       <= S_IDLE;
            tab_vld     <= '0;
            hit         <= '0;
            ord_q       <= 1'b0;
            hit_count   <= '0;
            cycle_count <= '0;
            fail_code   <= FC_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else if (start && (state != S_RUN)) begin
            hit         <= '0;
            ord_q       <= ordered;
            hit_count   <= '0;
            cycle_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            if (tab_vld == '0) begin
                state     <= S_FAIL;
                fail_code <= FC_EMPTY;
            end else begin
                state     <= S_RUN;
                fail_code <= FC_NONE;
            end
        end else if (state == S_RUN) begin
            // The counter parks at its last value so a timed-out run reports TIMEOUT-1.
            if (cycle_count != CNT_LAST) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
            if (mem_we && !match && !in_win) begin
                state     <= S_FAIL;
                fail_code <= FC_BAD;
                fail_addr <= mem_addr;
                fail_data <= mem_wdata;
            end else begin
                if (mem_we && match) begin
                    hit       <= hit | sel;
                    hit_count <= hit_count + HIT_ONE;
                end
                if (mem_we && match && all_done) begin
                    state <= S_PASS;
                end else if (cycle_count == CNT_LAST) begin
                    state     <= S_FAIL;
                    fail_code <= FC_TIMEOUT;
                end
            end
        end else if (cfg_write) begin
            tab_vld[cfg_idx] <= 1'b1;
        end
    end
endmodule

// File: doc/mem_store_checker.md
Name: mem_store_checker

Overview:
- Synthesizable self-check monitor on the pipelined core's data-memory write port (MemWriteM / DataAdr / WriteData), for use in testbenches and on-FPGA bring-up.
- Holds a programmable table of expected (address, data) stores and an ignore window for scratch writes.
- Checks the stores in ordered or unordered mode, with a cycle timeout.
- Reports sticky pass/fail with a cause code and the offending store.

Parameters:
ADDR_W, 32, data-memory address width
DATA_W, 32, store data width
N_EXP, 4, expected-store table depth (1..16)
IDX_W, 2, table index width, equal to clog2(N_EXP) and at least 1
CNT_W, 16, cycle counter width
TIMEOUT, 1000, run cycles allowed before timeout failure (1..2^CNT_W-1)

Ports:
clk  in  1  clock; all sampling on rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  write one table entry
cfg_idx  in  IDX_W  entry index
cfg_addr  in  ADDR_W  expected address
cfg_data  in  DATA_W  expected data
ordered  in  1  1 = entries must hit in ascending index order; sampled at start
ign_lo  in  ADDR_W  ignore-window low bound, inclusive
ign_hi  in  ADDR_W  ignore-window high bound, inclusive
start  in  1  arm or re-arm a check run
clear  in  1  return to IDLE and invalidate the table
mem_we  in  1  core store strobe (MemWriteM)
mem_addr  in  ADDR_W  store address (DataAdr)
mem_wdata  in  DATA_W  store data (WriteData)
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail_code  out  2  0 none, 1 bad store, 2 timeout, 3 empty table
fail_addr  out  ADDR_W  address of the offending store
fail_data  out  DATA_W  data of the offending store
hit_count  out  IDX_W+1  entries matched this run
cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0.
  - Table valid bits and hit bits cleared.
- States: IDLE, RUN, PASS, FAIL.
- Table writes:
  - cfg_we is honoured only in IDLE, PASS and FAIL; it is ignored in RUN.
  - It writes the entry and sets its valid bit.
  - cfg_idx >= N_EXP is ignored.
- Control priority when inputs coincide: clear > start > cfg_we.
- clear (any state): next cycle state=IDLE, table invalidated, all status outputs 0.
- start (IDLE/PASS/FAIL):
  - Zero valid entries: go to FAIL, fail_code=3, next cycle.
  - Otherwise go to RUN next cycle.
  - Hit bits, hit_count, cycle_count, fail_* and the order pointer are cleared; ordered is latched.
  - start in RUN is ignored.
- RUN, each cycle:
  - cycle_count increments.
  - If mem_we, classify the store in this priority:
    - Match: ordered=1, store equals the lowest-index valid unhit entry; or ordered=0, store equals any valid unhit entry (lowest index wins). The entry is marked hit and hit_count increments.
    - Ignored: address lies in [ign_lo, ign_hi]. No effect. A window with ign_lo > ign_hi is empty.
    - Otherwise: FAIL next cycle, fail_code=1, fail_addr/fail_data capture the store.
  - A store that re-hits an already-hit entry is a bad store, unless it falls in the ignore window.
  - Completion: the cycle after the last valid entry is hit, state=PASS (pass=1, done=1).
  - Timeout: if cycle_count reaches TIMEOUT-1 without completion, FAIL next cycle with fail_code=2, fail_addr/fail_data=0.
  - If the final match and the timeout occur on the same edge, the match wins (PASS).
- Equality is full-width on both address and data.
- PASS/FAIL are sticky: counters freeze and store inputs are ignored until start or clear.
- Outputs are registered; each verdict appears exactly 1 cycle after the deciding edge.
- Reset mid-RUN: immediate return to IDLE; the table is lost.

Test Plan:
- Single-entry pass: entry0=(100,7), window 96..96, start; stores (96,0x55) then (100,7) -> pass=1 one cycle later, hit_count=1, fail_code=0.
- Bad data: same setup, store (100,6) -> FAIL, fail_code=1, fail_addr=100, fail_data=6; a later store (100,7) leaves FAIL unchanged.
- Order modes: entries {0:(100,7), 1:(104,9)}, stores (104,9) then (100,7):
  - ordered=1 -> fail_code=1, fail_addr=104.
  - Re-run with ordered=0 -> pass, hit_count=2.
- Timeout: TIMEOUT=16, one entry, no stores -> FAIL, fail_code=2, cycle_count=15, busy drops exactly one cycle later. A final match on that same edge -> PASS instead.
- Empty table and control priority:
  - start with no entries -> fail_code=3.
  - clear asserted together with start -> IDLE.
  - cfg_we during RUN does not alter the table.
- Async reset mid-RUN: drop reset between clock edges -> busy=0 immediately. After release, start -> fail_code=3 (table invalidated).
